// File: rtl/commit_pkg.sv
// ============================================================================
// Module      : commit_pkg
// Description : Shared constants and the retired-instruction record type.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package commit_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        is_break;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
  } commit_entry_t;

endpackage

`default_nettype wire

// File: rtl/commit_fifo.sv
// ============================================================================
// Module      : commit_fifo
// Description : Small power-of-two FIFO of retired-instruction records.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module commit_fifo
  import commit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  commit_entry_t push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output commit_entry_t head
);

  localparam int c_addr_w = $clog2(DEPTH);

  commit_entry_t       r_mem [DEPTH];
  logic [c_addr_w:0]   r_wr_ptr;
  logic [c_addr_w:0]   r_rd_ptr;
  logic                w_do_push;
  logic                w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                 (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign head  = r_mem[r_rd_ptr[c_addr_w-1:0]];

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_do_push) r_mem[r_wr_ptr[c_addr_w-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/commit_stage.sv
// ============================================================================
// Module      : commit_stage
// Description : Retirement stage feeding the difftest model: FIFO, shadow ARF,
//               counters, halt and no-progress watchdog.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module commit_stage
  import commit_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [63:0]          wb_pc,
  input  logic [31:0]          wb_inst,
  input  logic                 wb_is_break,
  input  logic                 wb_rd_we,
  input  logic [4:0]           wb_rd_addr,
  input  logic [63:0]          wb_rd_data,
  input  logic                 cmt_stall,
  output logic                 cmt_valid,
  output logic [63:0]          cmt_pc,
  output logic [31:0]          cmt_inst,
  output logic                 cmt_halt,
  output logic                 cmt_timeout,
  output logic [XLEN*NREG-1:0] arf_flat,
  output logic [63:0]          cycle_cnt,
  output logic [63:0]          instret_cnt
);

  localparam int                c_wd_w    = $clog2(TIMEOUT) + 1;
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);

  commit_entry_t     w_push_data;
  commit_entry_t     w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  logic              r_brk_accepted;
  logic              r_cmt_valid;
  logic [63:0]       r_cmt_pc;
  logic [31:0]       r_cmt_inst;
  logic              r_cmt_halt;
  logic              r_cmt_timeout;
  logic [63:0]       r_cycle_cnt;
  logic [63:0]       r_instret_cnt;
  logic [c_wd_w-1:0] r_wd_cnt;
  logic [XLEN-1:0]   r_arf [NREG];

  // Ready depends only on registered state, so a full FIFO blocks a push even
  // when a pop happens in the same cycle.
  assign wb_ready = rst_n && !w_full && !r_brk_accepted && !r_cmt_halt;
  assign w_push   = wb_valid && wb_ready;
  assign w_pop    = !w_empty && !cmt_stall && !r_cmt_halt;

  assign w_push_data = '{pc:       wb_pc,
                         inst:     wb_inst,
                         is_break: wb_is_break,
                         rd_we:    wb_rd_we,
                         rd_addr:  wb_rd_addr,
                         rd_data:  wb_rd_data};

  commit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_brk_accepted <= 1'b0;
      r_cmt_valid    <= 1'b0;
      r_cmt_pc       <= '0;
      r_cmt_inst     <= '0;
      r_cmt_halt     <= 1'b0;
      r_instret_cnt  <= '0;
      r_cycle_cnt    <= '0;
    end else begin
      if (w_push && wb_is_break) r_brk_accepted <= 1'b1;
      r_cmt_valid <= w_pop;
      if (w_pop) begin
        r_cmt_pc      <= w_head.pc;
        r_cmt_inst    <= w_head.inst;
        r_instret_cnt <= r_instret_cnt + 64'd1;
        if (w_head.is_break) r_cmt_halt <= 1'b1;
      end
      if (!r_cmt_halt) r_cycle_cnt <= r_cycle_cnt + 64'd1;
    end
  end

  // Shadow ARF: the write lands on the pop edge, so it is visible with cmt_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_arf[i] <= '0;
    end else if (w_pop && w_head.rd_we && (w_head.rd_addr != 5'd0)) begin
      r_arf[w_head.rd_addr] <= w_head.rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wd_cnt      <= '0;
      r_cmt_timeout <= 1'b0;
    end else if (w_pop) begin
      r_wd_cnt <= '0;
    end else if (!cmt_stall && !r_cmt_halt) begin
      if (r_wd_cnt == c_wd_last) r_cmt_timeout <= 1'b1;
      else                       r_wd_cnt      <= r_wd_cnt + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_arf_flat
      assign arf_flat[gi*XLEN +: XLEN] = r_arf[gi];
    end
  endgenerate

  assign cmt_valid   = r_cmt_valid;
  assign cmt_pc      = r_cmt_pc;
  assign cmt_inst    = r_cmt_inst;
  assign cmt_halt    = r_cmt_halt;
  assign cmt_timeout = r_cmt_timeout;
  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;

endmodule

`default_nettype wire

// File: tb/tb_commit_stage.sv
// ============================================================================
// Module      : tb_commit_stage
// Description : Self-checking bench for commit_stage against a queue model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_commit_stage;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wb_valid = 1'b0;
  logic           wb_ready;
  logic [63:0]    wb_pc = '0;
  logic [31:0]    wb_inst = '0;
  logic           wb_is_break = 1'b0;
  logic           wb_rd_we = 1'b0;
  logic [4:0]     wb_rd_addr = '0;
  logic [63:0]    wb_rd_data = '0;
  logic           cmt_stall = 1'b0;
  logic           cmt_valid;
  logic [63:0]    cmt_pc;
  logic [31:0]    cmt_inst;
  logic           cmt_halt;
  logic           cmt_timeout;
  logic [2047:0]  arf_flat;
  logic [63:0]    cycle_cnt;
  logic [63:0]    instret_cnt;

  commit_stage #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_is_break(wb_is_break),
    .wb_rd_we(wb_rd_we), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .cmt_stall(cmt_stall), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
    .cmt_inst(cmt_inst), .cmt_halt(cmt_halt), .cmt_timeout(cmt_timeout),
    .arf_flat(arf_flat), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        brk;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] data;
  } rec_t;

  // Reference model: retired records waiting in order, plus architectural state.
  rec_t        q[$];
  logic [63:0] m_arf [32];
  logic [63:0] m_cycle, m_instret, m_pc;
  logic [31:0] m_inst;
  logic        m_valid, m_halt, m_brk, m_timeout, m_pushed;
  int          m_wd;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_ready();
    return rst_n && (q.size() < DEPTH) && !m_brk && !m_halt;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) m_arf[i] = '0;
    m_cycle = '0; m_instret = '0; m_pc = '0; m_inst = '0;
    m_valid = 0; m_halt = 0; m_brk = 0; m_timeout = 0; m_wd = 0;
  endtask

  task automatic check_all();
    chk("wb_ready", wb_ready, m_ready());
    chk("cmt_valid", cmt_valid, m_valid);
    chk("cmt_pc", cmt_pc, m_pc);
    chk("cmt_inst", cmt_inst, m_inst);
    chk("cmt_halt", cmt_halt, m_halt);
    chk("cmt_timeout", cmt_timeout, m_timeout);
    chk("cycle_cnt", cycle_cnt, m_cycle);
    chk("instret_cnt", instret_cnt, m_instret);
    for (int i = 0; i < 32; i++) chk($sformatf("arf_x%0d", i), arf_flat[i*64 +: 64], m_arf[i]);
  endtask

  // One clock: decide model events from pre-edge state, clock the DUT, compare.
  task automatic step();
    bit   do_push, do_pop, old_halt;
    rec_t in_r, e;
    in_r = '{pc: wb_pc, inst: wb_inst, brk: wb_is_break, we: wb_rd_we,
             rd: wb_rd_addr, data: wb_rd_data};
    do_push  = wb_valid && m_ready();
    do_pop   = rst_n && (q.size() > 0) && !cmt_stall && !m_halt;
    old_halt = m_halt;
    @(posedge clk);
    #1;
    m_pushed = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_valid = do_pop;
      if (do_pop) begin
        e = q.pop_front();
        m_pc = e.pc;
        m_inst = e.inst;
        if (e.we && e.rd != 0) m_arf[e.rd] = e.data;
        m_instret = m_instret + 1;
        if (e.brk) m_halt = 1;
      end
      if (do_push) begin
        q.push_back(in_r);
        m_pushed = 1;
        if (in_r.brk) m_brk = 1;
      end
      if (!old_halt) m_cycle = m_cycle + 1;
      if (do_pop) m_wd = 0;
      else if (!cmt_stall && !old_halt) begin
        if (m_wd == TIMEOUT - 1) m_timeout = 1;
        else m_wd++;
      end
    end
    check_all();
  endtask

  task automatic drive(input rec_t r);
    wb_pc = r.pc; wb_inst = r.inst; wb_is_break = r.brk;
    wb_rd_we = r.we; wb_rd_addr = r.rd; wb_rd_data = r.data;
  endtask

  function automatic rec_t rand_rec(input logic [63:0] pc);
    rec_t r;
    r.pc = pc; r.inst = $urandom; r.brk = 0; r.we = $urandom_range(0, 1);
    r.rd = 5'($urandom_range(0, 31)); r.data = {$urandom, $urandom};
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 0; wb_valid = 0; cmt_stall = 0;
    step();
    rst_n = 1;
  endtask

  // Offer a record until accepted, with a bounded wait.
  task automatic offer(input rec_t r);
    int guard = 0;
    drive(r);
    wb_valid = 1;
    step();
    while (!m_pushed && guard < 20) begin step(); guard++; end
    chk("offer_accepted", m_pushed, 1'b1);
    wb_valid = 0;
  endtask

  initial begin
    rec_t r, bp [5];
    model_reset();
    rst_n = 0;
    step();
    step();
    chk("reset_ready_low", wb_ready, 1'b0);
    rst_n = 1;

    // Single write to x1, visible two edges after the push.
    drive('{pc: 64'h8000_0000, inst: 32'h0050_0093, brk: 0, we: 1, rd: 5'd1, data: 64'd5});
    wb_valid = 1;
    step();
    wb_valid = 0;
    step();
    chk("single_valid", cmt_valid, 1'b1);
    chk("single_pc", cmt_pc, 64'h8000_0000);
    chk("single_x1", arf_flat[127:64], 64'd5);
    chk("single_instret", instret_cnt, 64'd1);
    step();
    chk("single_pulse_end", cmt_valid, 1'b0);

    // Write to x0 is dropped.
    drive('{pc: 64'h8000_0004, inst: 32'h0000_0013, brk: 0, we: 1, rd: 5'd0, data: 64'hdead});
    wb_valid = 1;
    step();
    wb_valid = 0;
    step();
    chk("x0_valid", cmt_valid, 1'b1);
    chk("x0_zero", arf_flat[63:0], 64'd0);

    // Backpressure: fill under stall, fifth refused, then drain in order.
    cmt_stall = 1;
    for (int k = 0; k < 5; k++) bp[k] = rand_rec(64'h8000_0100 + 64'(k * 4));
    for (int k = 0; k < 4; k++) offer(bp[k]);
    drive(bp[4]);
    wb_valid = 1;
    step();
    chk("full_ready_low", wb_ready, 1'b0);
    cmt_stall = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drain_valid", cmt_valid, 1'b1);
      chk("drain_pc", cmt_pc, 64'h8000_0100 + 64'(k * 4));
    end
    wb_valid = 0;
    step();
    step();
    chk("fifth_pc", cmt_pc, 64'h8000_0110);

    // Randomized traffic without breaks.
    for (int n = 0; n < 300; n++) begin
      r = rand_rec({32'h8000_0000, 20'h0, 12'($urandom_range(0, 1023) * 4)});
      drive(r);
      wb_valid = ($urandom_range(0, 3) != 0);
      cmt_stall = ($urandom_range(0, 3) == 0);
      step();
    end
    wb_valid = 0;
    cmt_stall = 0;

    // Watchdog: idle after reset fires after TIMEOUT cycles and sticks.
    do_reset();
    for (int n = 0; n < TIMEOUT - 1; n++) step();
    chk("wd_not_yet", cmt_timeout, 1'b0);
    step();
    chk("wd_fired", cmt_timeout, 1'b1);
    for (int n = 0; n < 5; n++) step();
    chk("wd_sticky", cmt_timeout, 1'b1);
    do_reset();
    cmt_stall = 1;
    for (int n = 0; n < 3 * TIMEOUT; n++) step();
    chk("wd_stalled", cmt_timeout, 1'b0);
    cmt_stall = 0;

    // Mid-operation reset discards buffered entries.
    do_reset();
    cmt_stall = 1;
    for (int k = 0; k < 3; k++) offer(rand_rec(64'h8000_0200 + 64'(k * 4)));
    rst_n = 0;
    step();
    chk("midrst_cycle", cycle_cnt, 64'd0);
    chk("midrst_ready", wb_ready, 1'b0);
    rst_n = 1;
    cmt_stall = 0;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("midrst_no_stale", cmt_valid, 1'b0);
    end

    // Break: third record refused, halt with break pc, cycle count frozen.
    do_reset();
    offer('{pc: 64'h8000_000c, inst: 32'h0010_0113, brk: 0, we: 1, rd: 5'd2, data: 64'd1});
    offer('{pc: 64'h8000_0010, inst: 32'h0010_0073, brk: 1, we: 0, rd: 5'd0, data: 64'd0});
    chk("brk_ready_low", wb_ready, 1'b0);
    drive(rand_rec(64'h8000_0014));
    wb_valid = 1;
    for (int n = 0; n < 3; n++) step();
    chk("brk_halt", cmt_halt, 1'b1);
    chk("brk_pc", cmt_pc, 64'h8000_0010);
    chk("brk_third_refused", wb_ready, 1'b0);
    for (int n = 0; n < 10; n++) step();
    chk("brk_instret", instret_cnt, 64'd2);
    wb_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
